// File: rtl/semaforo_n_vias.sv
// Round-robin, demand-actuated traffic light for N_WAYS conflicting approaches,
// with timed green, yellow and all-red intervals plus a flashing-yellow mode.
module semaforo_n_vias #(
    parameter int N_WAYS   = 4,
    parameter int T_GREEN  = 8,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_WAYS-1:0]           demand,
    input  logic                        flash,
    output logic [N_WAYS-1:0]           green,
    output logic [N_WAYS-1:0]           yellow,
    output logic [N_WAYS-1:0]           red,
    output logic [$clog2(N_WAYS)-1:0]   active_way,
    output logic [1:0]                  phase
);

    localparam int PW   = $clog2(N_WAYS);
    localparam int TGY  = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
    localparam int TMAX = (TGY > T_ALLRED) ? TGY : T_ALLRED;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        ALL_RED = 2'b00,
        GREEN   = 2'b01,
        YELLOW  = 2'b10,
        FLASH   = 2'b11
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            blink, blink_n;

    logic [PW-1:0]     nxt_way;
    logic              found;
    logic [N_WAYS-1:0] way_mask;
    logic              conflict;
    logic              cnt_zero;

    assign cnt_zero = (cnt == '0);
    assign way_mask = {{(N_WAYS-1){1'b0}}, 1'b1} << ptr;
    assign conflict = |(demand & ~way_mask);

    // Scan ptr+1 .. ptr+N_WAYS so that ptr itself is considered last.
    always_comb begin
        nxt_way = PW'((int'(ptr) + 1) % N_WAYS);
        found   = 1'b0;
        for (int i = 1; i <= N_WAYS; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N_WAYS;
            if (!found && demand[idx]) begin
                nxt_way = PW'(idx);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt_zero ? cnt : cnt - CW'(1);
        blink_n = blink;
        if (flash) begin
            if (state != FLASH) begin
                state_n = FLASH;
                blink_n = 1'b1;
                cnt_n   = CW'(T_YELLOW - 1);
            end else if (cnt_zero) begin
                blink_n = ~blink;
                cnt_n   = CW'(T_YELLOW - 1);
            end
        end else begin
            unique case (state)
                ALL_RED: begin
                    if (cnt_zero) begin
                        state_n = GREEN;
                        ptr_n   = nxt_way;
                        cnt_n   = CW'(T_GREEN - 1);
                    end
                end
                GREEN: begin
                    if (cnt_zero && conflict) begin
                        state_n = YELLOW;
                        cnt_n   = CW'(T_YELLOW - 1);
                    end
                end
                YELLOW: begin
                    if (cnt_zero) begin
                        state_n = ALL_RED;
                        cnt_n   = CW'(T_ALLRED - 1);
                    end
                end
                FLASH: begin
                    state_n = ALL_RED;
                    blink_n = 1'b0;
                    cnt_n   = CW'(T_ALLRED - 1);
                end
                default: state_n = ALL_RED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ALL_RED;
            ptr   <= PW'(N_WAYS - 1);
            cnt   <= CW'(T_ALLRED - 1);
            blink <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            blink <= blink_n;
        end
    end

    always_comb begin
        green  = '0;
        yellow = '0;
        red    = '1;
        unique case (state)
            ALL_RED: ;
            GREEN: begin
                green = way_mask;
                red   = ~way_mask;
            end
            YELLOW: begin
                yellow = way_mask;
                red    = ~way_mask;
            end
            FLASH: begin
                red    = '0;
                yellow = {N_WAYS{blink}};
            end
            default: ;
        endcase
    end

    assign active_way = ptr;
    assign phase      = state;

endmodule

// File: tb/tb_semaforo_n_vias.sv
// Directed-vector bench for semaforo_n_vias: reset, actuation, round-robin,
// green extension, flash mode and reset during yellow.
module tb_semaforo_n_vias;

    logic       clk;
    logic       reset;
    logic [3:0] demand;
    logic       flash;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [3:0] red;
    logic [1:0] active_way;
    logic [1:0] phase;

    int tests  = 0;
    int errors = 0;

    semaforo_n_vias #(
        .N_WAYS  (4),
        .T_GREEN (5),
        .T_YELLOW(3),
        .T_ALLRED(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .demand    (demand),
        .flash     (flash),
        .green     (green),
        .yellow    (yellow),
        .red       (red),
        .active_way(active_way),
        .phase     (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic count_while(input logic [1:0] p, output int n);
        n = 0;
        while (phase == p && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_green(input logic [1:0] way);
        int n;
        n = 0;
        while (!(phase == 2'b01 && active_way == way) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("wait_green_timeout", 32'(n < 200), 1);
    endtask

    task automatic next_green(output logic [1:0] way);
        int n;
        n = 0;
        while (phase == 2'b01 && n < 100) begin
            n++;
            @(negedge clk);
        end
        while (phase != 2'b01 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("next_green_timeout", 32'(n < 100), 1);
        way = active_way;
    endtask

    initial begin
        int n;
        logic [1:0] w;
        logic [1:0] rr_exp [4];
        rr_exp = '{2'd2, 2'd0, 2'd2, 2'd0};

        reset  = 1'b1;
        demand = 4'b0000;
        flash  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_red", red, 4'b1111);
        check("rst_green", green, 4'b0000);
        check("rst_phase", phase, 2'b00);
        check("rst_way", active_way, 2'd3);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("first_green", green, 4'b0001);
        check("first_phase", phase, 2'b01);
        check("first_way", active_way, 2'd0);
        repeat (10) @(negedge clk);
        check("green_hold", green, 4'b0001);

        // Actuation from a fresh green on way 0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("act_g1", green, 4'b0001);
        demand = 4'b1000;
        count_while(2'b01, n);
        check("act_green_len", n, 5);
        check("act_yellow_lamp", yellow, 4'b0001);
        count_while(2'b10, n);
        check("act_yellow_len", n, 3);
        check("act_allred_lamp", red, 4'b1111);
        count_while(2'b00, n);
        check("act_allred_len", n, 2);
        check("act_next_green", green, 4'b1000);
        check("act_next_way", active_way, 2'd3);

        // Round-robin with wrap
        demand = 4'b0010;
        wait_green(2'd1);
        demand = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            next_green(w);
            check($sformatf("rr_serve%0d", k), w, rr_exp[k]);
        end

        // Green extension on way 0
        demand = 4'b0001;
        repeat (8) @(negedge clk);
        check("ext_g9", phase, 2'b01);
        demand = 4'b0010;
        @(negedge clk);
        check("ext_yellow_phase", phase, 2'b10);
        check("ext_yellow_lamp", yellow, 4'b0001);

        // Flash during green on way 2
        wait_green(2'd1);
        demand = 4'b0100;
        wait_green(2'd2);
        flash  = 1'b1;
        demand = 4'b0000;
        @(negedge clk);
        check("fl_phase", phase, 2'b11);
        check("fl_way", active_way, 2'd2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fl_on%0d", i), yellow, 4'b1111);
            check($sformatf("fl_red%0d", i), {green, red}, 8'h00);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fl_off%0d", i), yellow, 4'b0000);
            @(negedge clk);
        end
        check("fl_on_again", yellow, 4'b1111);
        flash  = 1'b0;
        demand = 4'b0001;
        @(negedge clk);
        count_while(2'b00, n);
        check("fl_allred_len", n, 2);
        check("fl_exit_green", green, 4'b0001);
        check("fl_exit_way", active_way, 2'd0);

        // Reset mid-yellow
        demand = 4'b0010;
        n = 0;
        while (phase != 2'b10 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("ry_reach_yellow", phase, 2'b10);
        reset = 1'b1;
        @(negedge clk);
        check("ry_red", red, 4'b1111);
        check("ry_way", active_way, 2'd3);
        check("ry_phase", phase, 2'b00);
        reset  = 1'b0;
        demand = 4'b0000;
        @(negedge clk);
        check("ry_allred2", phase, 2'b00);
        @(negedge clk);
        check("ry_green", green, 4'b0001);
        check("ry_green_way", active_way, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/semaforo_n_vias.md
# semaforo_n_vias

Timed traffic-light controller for an intersection of N_WAYS conflicting approaches. It generalises the two-way sensor-decoded light into a clocked, demand-actuated, round-robin controller. It enforces minimum green, yellow and all-red clearance intervals and provides a flashing-yellow maintenance mode. It drives lamp outputs directly and exposes phase and active-way status for the board display logic.

## Interface
- N_WAYS, 4: number of approaches, 2..8.
- T_GREEN, 8: minimum green duration in clk cycles, ≥1.
- T_YELLOW, 3: yellow duration in cycles, ≥1; also the flash half-period.
- T_ALLRED, 2: all-red clearance in cycles, ≥1.

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- demand  in  N_WAYS  per-way vehicle/pedestrian request, level, synchronous to clk.
- flash  in  1  maintenance mode request, level.
- green  out  N_WAYS  green lamp per way.
- yellow  out  N_WAYS  yellow lamp per way.
- red  out  N_WAYS  red lamp per way.
- active_way  out  $clog2(N_WAYS)  way currently or last served.
- phase  out  2  00 ALL_RED, 01 GREEN, 10 YELLOW, 11 FLASH.

## Operation
- Moore machine. All outputs decode from registered state (state, ptr, counter, blink) only; no combinational path from inputs to outputs.
- Lamp rule: exactly one of green/yellow/red is high per way in ALL_RED/GREEN/YELLOW. Only way ptr may be non-red. In FLASH, red=0, green=0, yellow = all ones when blink=1, else all zeros.
- Down-counter width is $clog2(max(T_GREEN,T_YELLOW,T_ALLRED)+1). It is loaded with T_x−1 on entry to a state.
- ALL_RED: all red. At counter==0, select the next way as the first way with demand=1, scanning ptr+1, ptr+2, … modulo N_WAYS, with ptr itself checked last. If no way has demand, select ptr+1 mod N_WAYS. Load ptr, go to GREEN.
- GREEN: green[ptr]=1. Decrement counter to 0 and hold at 0. While counter==0, if any demand[j] with j≠ptr, go to YELLOW. Otherwise stay in GREEN (green extension; no upper bound).
- YELLOW: yellow[ptr]=1. At counter==0, go to ALL_RED.
- FLASH: when flash=1, enter from any state on the next edge. On entry, blink=1 and counter=T_YELLOW−1. At counter==0, toggle blink and reload. When flash=0 in FLASH, go to ALL_RED with ptr unchanged.
- flash takes priority over every other transition. reset takes priority over flash.
- Demand is not latched. A request dropped before it is sampled is lost.

## Timing
- Reset values: state=ALL_RED, ptr=N_WAYS−1, counter=T_ALLRED−1, blink=0. Therefore red=all ones, green=0, yellow=0, active_way=N_WAYS−1, phase=00.
- Reset asserted mid-operation forces reset values on the following edge, regardless of state.
- Interval durations, as cycles the lamp is visible:
  - ALL_RED: exactly T_ALLRED.
  - YELLOW: exactly T_YELLOW.
  - GREEN: T_GREEN if conflicting demand is present at expiry. Otherwise T_GREEN+k, where k is the number of cycles after expiry until conflicting demand is first sampled.
  - FLASH: each yellow on/off half-period is exactly T_YELLOW.
- Demand sampled high at a GREEN expiry edge gives YELLOW on the next cycle, i.e. one-cycle decision latency.
- Round-robin wrap: ptr=N_WAYS−1 scans 0,1,…,N_WAYS−1.
- Only ptr demanding at ALL_RED end: the same way is re-served.
- Simultaneous demands: the nearest way after ptr wins.

## Test plan
- Reset: N_WAYS=4, T_GREEN=5, T_YELLOW=3, T_ALLRED=2, demand=0. Hold reset 2 cycles → red=1111, phase=00, active_way=3. Release → 2 cycles later green=0001, phase=01, active_way=0. Green holds indefinitely with no demand.
- Actuation: way 0 green with demand=1000 from green cycle 1 → green lasts exactly 5 cycles, yellow[0] 3 cycles, red=1111 2 cycles, then green=1000, active_way=3.
- Round-robin and wrap: way 1 green, demand=0101 held → served order 2, 0, 2, 0. Way 1 is never served.
- Extension: way 0 green, demand=0010 first asserted 4 cycles after expiry → green lasts 9 cycles, and YELLOW begins the cycle after demand is sampled.
- Flash: flash=1 mid-GREEN on way 2 → next cycle phase=11, yellow=1111 for 3 cycles, 0000 for 3, repeating. flash=0 → ALL_RED 2 cycles, then next demanding way after 2.
- Reset mid-YELLOW: reset for 1 cycle → next cycle red=1111, active_way=3, phase=00, and the normal sequence restarts.
